// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// master: controller (consumes IR fields/Zero, drives enables/selects); slave: datapath.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [3:0] State;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite,
    output RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
    output ImmSrc, ALUControl, State,
    output InstrDone, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite,
    input  RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
    input  ImmSrc, ALUControl, State,
    input  InstrDone, Illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore main controller for the multicycle RV32I core: sequences the shared datapath.
// Ports: clk, reset (sync, active-high), bus (master: IR fields/Zero in, controls out).
module multicycle_controller (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXEI   = 4'd8,
    S_JAL    = 4'd9,
    S_BEQ    = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] AOP_ADD  = 2'b00;
  localparam logic [1:0] AOP_SUB  = 2'b01;
  localparam logic [1:0] AOP_FN   = 2'b10;

  localparam logic [3:0] A_ADD  = 4'b0000;
  localparam logic [3:0] A_SUB  = 4'b0001;
  localparam logic [3:0] A_AND  = 4'b0010;
  localparam logic [3:0] A_OR   = 4'b0011;
  localparam logic [3:0] A_XOR  = 4'b0100;
  localparam logic [3:0] A_SLT  = 4'b0101;
  localparam logic [3:0] A_SLTU = 4'b0110;
  localparam logic [3:0] A_SLL  = 4'b0111;
  localparam logic [3:0] A_SRL  = 4'b1000;
  localparam logic [3:0] A_SRA  = 4'b1001;

  state_t     state_q;
  state_t     state_n;
  state_t     cur;

  logic       is_mem;
  logic       is_r;
  logic       is_i;
  logic       is_br;
  logic       is_jal;

  logic       pcupdate;
  logic       branch;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       done;
  logic       illegal;
  logic [1:0] resultsrc;
  logic [1:0] srca;
  logic [1:0] srcb;
  logic [1:0] aluop;
  logic [1:0] immsrc;
  logic       f7g;
  logic [3:0] aluctl;

  assign is_mem = (bus.op == OP_LOAD) | (bus.op == OP_STORE);
  assign is_r   = (bus.op == OP_R);
  assign is_i   = (bus.op == OP_I);
  assign is_br  = (bus.op == OP_BR);
  assign is_jal = (bus.op == OP_JAL);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  // While reset is held the outputs decode as Fetch, whatever the register holds.
  assign cur = reset ? S_FETCH : state_q;

  always_comb begin
    state_n   = S_FETCH;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    resultsrc = 2'b00;
    srca      = 2'b00;
    srcb      = 2'b00;
    aluop     = AOP_ADD;
    case (cur)
      S_FETCH: begin
        state_n   = S_DECODE;
        irwrite   = 1'b1;
        pcupdate  = 1'b1;
        srcb      = 2'b10;
        resultsrc = 2'b10;
      end
      S_DECODE: begin
        // Branch/jump target is precomputed into ALUOut here.
        srca = 2'b01;
        srcb = 2'b01;
        unique case (1'b1)
          is_mem:  state_n = S_MEMADR;
          is_r:    state_n = S_EXER;
          is_i:    state_n = S_EXEI;
          is_br:   state_n = S_BEQ;
          is_jal:  state_n = S_JAL;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        state_n = bus.op[5] ? S_MEMWR : S_MEMRD;
        srca    = 2'b10;
        srcb    = 2'b01;
      end
      S_MEMRD: begin
        state_n = S_MEMWB;
        adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        done      = 1'b1;
      end
      S_MEMWR: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        done     = 1'b1;
      end
      S_EXER: begin
        state_n = S_ALUWB;
        srca    = 2'b10;
        aluop   = AOP_FN;
      end
      S_EXEI: begin
        state_n = S_ALUWB;
        srca    = 2'b10;
        srcb    = 2'b01;
        aluop   = AOP_FN;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_JAL: begin
        state_n  = S_ALUWB;
        srca     = 2'b01;
        srcb     = 2'b10;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        srca   = 2'b10;
        aluop  = AOP_SUB;
        branch = 1'b1;
        done   = 1'b1;
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    immsrc = 2'b00;
    case (bus.op)
      OP_STORE: immsrc = 2'b01;
      OP_BR:    immsrc = 2'b10;
      OP_JAL:   immsrc = 2'b11;
      default:  immsrc = 2'b00;
    endcase
  end

  // Only R-type or shift-right-immediate may use IR[30]; addi with a
  // negative immediate must stay an add.
  assign f7g = bus.funct7b5 & (bus.op[5] | (bus.funct3 == 3'b101));

  always_comb begin
    aluctl = A_ADD;
    case (aluop)
      AOP_ADD: aluctl = A_ADD;
      AOP_SUB: aluctl = A_SUB;
      AOP_FN: begin
        case (bus.funct3)
          3'b000:  aluctl = f7g ? A_SUB : A_ADD;
          3'b001:  aluctl = A_SLL;
          3'b010:  aluctl = A_SLT;
          3'b011:  aluctl = A_SLTU;
          3'b100:  aluctl = A_XOR;
          3'b101:  aluctl = f7g ? A_SRA : A_SRL;
          3'b110:  aluctl = A_OR;
          default: aluctl = A_AND;
        endcase
      end
      default: aluctl = A_ADD;
    endcase
  end

  // bne inverts the taken sense via funct3[0].
  assign bus.PCWrite    = ~reset &
                          (pcupdate |
                           (branch & (bus.Zero ^ bus.funct3[0])));
  assign bus.IRWrite    = ~reset & irwrite;
  assign bus.RegWrite   = ~reset & regwrite;
  assign bus.MemWrite   = ~reset & memwrite;
  assign bus.InstrDone  = ~reset & done;
  assign bus.Illegal    = ~reset & illegal;
  assign bus.AdrSrc     = adrsrc;
  assign bus.ResultSrc  = resultsrc;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ImmSrc     = immsrc;
  assign bus.ALUControl = aluctl;
  assign bus.State      = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table,
// hand-written corner sequences and random instructions vs. a class-level model.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  int passed = 0;
  int total  = 0;
  int ncyc;

  logic [3:0] st [8];
  logic       pcw[8];
  logic       irw[8];
  logic       rw [8];
  logic       mw [8];
  logic       dn [8];
  logic       il [8];
  logic       adr[8];
  logic [1:0] rs [8];
  logic [1:0] sa [8];
  logic [1:0] sb [8];
  logic [1:0] im [8];
  logic [3:0] alu[8];

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         ncyc;
    logic       chk_alu;
    logic [3:0] alu;
    logic       pcw2;
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Executes one instruction from Fetch, recording every cycle's outputs.
  // Entry/exit point: 1 time unit after a rising edge with the DUT in Fetch.
  task automatic run_instr(logic [6:0] o, logic [2:0] f3,
                           logic f7, logic z);
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    bus.Zero = z;
    ncyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      st[i]  = bus.State;
      pcw[i] = bus.PCWrite;
      irw[i] = bus.IRWrite;
      rw[i]  = bus.RegWrite;
      mw[i]  = bus.MemWrite;
      dn[i]  = bus.InstrDone;
      il[i]  = bus.Illegal;
      adr[i] = bus.AdrSrc;
      rs[i]  = bus.ResultSrc;
      sa[i]  = bus.ALUSrcA;
      sb[i]  = bus.ALUSrcB;
      im[i]  = bus.ImmSrc;
      alu[i] = bus.ALUControl;
      ncyc = i + 1;
      @(posedge clk);
      #1;
      if (bus.State == 4'd0) break;
    end
    check("cycle_budget", 32'(ncyc < 8), 1);
  endtask

  // Instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 illegal.
  function automatic int cls(logic [6:0] o);
    case (o)
      LW:      return 0;
      SW:      return 1;
      RT:      return 2;
      IT:      return 3;
      BR:      return 4;
      JL:      return 5;
      default: return 6;
    endcase
  endfunction

  // ALU operation implied by the RV32I mnemonic.
  function automatic logic [3:0] alu_ref(logic [6:0] o, logic [2:0] f3,
                                         logic f7);
    int c;
    c = cls(o);
    if (c == 4) return 4'd1;
    if (c != 2 && c != 3) return 4'd0;
    case (f3)
      3'd0: return (c == 2 && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  task automatic model_check(string tag, logic [6:0] o,
                             logic [2:0] f3, logic f7, logic z);
    int c;
    int es[$];
    logic [7:0] m_pcw, m_irw, m_rw, m_mw, m_dn, m_il;
    logic [7:0] e_pcw, e_rw, e_mw, e_dn, e_il;
    logic [1:0] e_im;
    c = cls(o);
    case (c)
      0: es = '{0, 1, 2, 3, 4};
      1: es = '{0, 1, 2, 5};
      2: es = '{0, 1, 6, 7};
      3: es = '{0, 1, 8, 7};
      4: es = '{0, 1, 10};
      5: es = '{0, 1, 9, 7};
      default: es = '{0, 1};
    endcase
    check({tag, ".ncyc"}, ncyc, es.size());
    for (int i = 0; i < es.size() && i < ncyc; i++)
      check($sformatf("%s.st%0d", tag, i), st[i], es[i]);
    m_pcw = '0; m_irw = '0; m_rw = '0;
    m_mw  = '0; m_dn  = '0; m_il = '0;
    for (int i = 0; i < ncyc; i++) begin
      m_pcw[i] = pcw[i]; m_irw[i] = irw[i]; m_rw[i] = rw[i];
      m_mw[i]  = mw[i];  m_dn[i]  = dn[i];  m_il[i] = il[i];
    end
    e_pcw = 8'h01;
    if (c == 5 || (c == 4 && (z ^ f3[0]))) e_pcw = 8'h05;
    e_rw = (c == 0) ? 8'h10 :
           (c == 2 || c == 3 || c == 5) ? 8'h08 : 8'h00;
    e_mw = (c == 1) ? 8'h08 : 8'h00;
    e_dn = (c == 6) ? 8'h00 : 8'(1 << (es.size() - 1));
    e_il = (c == 6) ? 8'h02 : 8'h00;
    e_im = (c == 1) ? 2'd1 : (c == 4) ? 2'd2 :
           (c == 5) ? 2'd3 : 2'd0;
    check({tag, ".pcw"}, m_pcw, e_pcw);
    check({tag, ".irw"}, m_irw, 8'h01);
    check({tag, ".rw"},  m_rw,  e_rw);
    check({tag, ".mw"},  m_mw,  e_mw);
    check({tag, ".done"}, m_dn, e_dn);
    check({tag, ".ill"}, m_il,  e_il);
    check({tag, ".imm"}, im[1], e_im);
    check({tag, ".alu0"}, alu[0], 0);
    if (c != 6 && ncyc > 2)
      check({tag, ".alu2"}, alu[2], alu_ref(o, f3, f7));
  endtask

  vec_t vt[15];

  initial begin
    vt[0]  = '{LW,  3'd2, 1'b0, 1'b0, 5, 1'b1, 4'd0, 1'b0};
    vt[1]  = '{SW,  3'd2, 1'b0, 1'b0, 4, 1'b1, 4'd0, 1'b0};
    vt[2]  = '{RT,  3'd0, 1'b1, 1'b0, 4, 1'b1, 4'd1, 1'b0};
    vt[3]  = '{RT,  3'd0, 1'b0, 1'b0, 4, 1'b1, 4'd0, 1'b0};
    vt[4]  = '{IT,  3'd0, 1'b1, 1'b0, 4, 1'b1, 4'd0, 1'b0};
    vt[5]  = '{IT,  3'd5, 1'b1, 1'b0, 4, 1'b1, 4'd9, 1'b0};
    vt[6]  = '{IT,  3'd5, 1'b0, 1'b0, 4, 1'b1, 4'd8, 1'b0};
    vt[7]  = '{RT,  3'd7, 1'b0, 1'b0, 4, 1'b1, 4'd2, 1'b0};
    vt[8]  = '{RT,  3'd3, 1'b0, 1'b0, 4, 1'b1, 4'd6, 1'b0};
    vt[9]  = '{BR,  3'd0, 1'b0, 1'b1, 3, 1'b1, 4'd1, 1'b1};
    vt[10] = '{BR,  3'd0, 1'b0, 1'b0, 3, 1'b1, 4'd1, 1'b0};
    vt[11] = '{BR,  3'd1, 1'b0, 1'b0, 3, 1'b1, 4'd1, 1'b1};
    vt[12] = '{BR,  3'd1, 1'b0, 1'b1, 3, 1'b1, 4'd1, 1'b0};
    vt[13] = '{JL,  3'd0, 1'b0, 1'b0, 4, 1'b1, 4'd0, 1'b1};
    vt[14] = '{BAD, 3'd0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0};

    reset = 1'b1;
    bus.op = LW;
    bus.funct3 = 3'd2;
    bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.state", bus.State, 0);
    check("rst.pcw", bus.PCWrite, 0);
    check("rst.irw", bus.IRWrite, 0);
    check("rst.done", bus.InstrDone, 0);
    check("rst.srcb", bus.ALUSrcB, 2);
    check("rst.rsrc", bus.ResultSrc, 2);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table of directed vectors.
    foreach (vt[k]) begin
      run_instr(vt[k].op, vt[k].f3, vt[k].f7, vt[k].z);
      check($sformatf("vec%0d.ncyc", k), ncyc, vt[k].ncyc);
      if (vt[k].chk_alu)
        check($sformatf("vec%0d.alu", k), alu[2], vt[k].alu);
      if (vt[k].ncyc > 2)
        check($sformatf("vec%0d.pcw2", k), pcw[2], vt[k].pcw2);
      model_check($sformatf("vec%0d", k),
                  vt[k].op, vt[k].f3, vt[k].f7, vt[k].z);
    end

    // lw datapath selects.
    run_instr(LW, 3'd2, 1'b0, 1'b0);
    check("lw.adr3", adr[3], 1);
    check("lw.adr2", adr[2], 0);
    check("lw.rs4", rs[4], 1);
    check("lw.sa2", sa[2], 2);
    check("lw.sb2", sb[2], 1);

    // jal selects.
    run_instr(JL, 3'd0, 1'b0, 1'b0);
    check("jal.sa2", sa[2], 1);
    check("jal.sb2", sb[2], 2);
    check("jal.rs3", rs[3], 0);
    check("jal.dec_sa", sa[1], 1);

    // Reset during MemWrite: no write that cycle, Fetch follows.
    bus.op = SW;
    bus.funct3 = 3'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.State == 4'd5) break;
    end
    check("rstmw.reach", bus.State, 5);
    check("rstmw.mw_pre", bus.MemWrite, 1);
    reset = 1'b1;
    #1;
    check("rstmw.mw", bus.MemWrite, 0);
    check("rstmw.done", bus.InstrDone, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmw.state", bus.State, 0);
    check("rstmw.irw", bus.IRWrite, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random instructions against the class-level model.
    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      logic [2:0] f3;
      logic f7, z;
      case ($urandom_range(0, 6))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        5: o = JL;
        default: o = 7'($urandom_range(0, 127));
      endcase
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      run_instr(o, f3, f7, z);
      model_check($sformatf("rnd%0d", n), o, f3, f7, z);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style main controller for the multicycle RV32I core variant. It sequences the shared datapath (single memory port, single ALU, PC/IR/OldPC/ALUOut/Data registers) through a fixed state machine per instruction class. It generates ALUOp internally and drives the existing ALU decoder to produce ALUControl. It also emits per-instruction retire and illegal-opcode pulses.

## Interface
- No parameters.
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR/OldPC enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1 register
- ALUSrcB  out  2  00=RD2 register, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
- State  out  4  current state code (debug)
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- Illegal  out  1  one-cycle pulse when Decode sees an unsupported opcode

## Operation
- States and codes:
  - Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5
  - ExecuteR=6, ALUWB=7, ExecuteI=8, JAL=9, BEQ=10
  - Codes 11–15 are unreachable and go to Fetch next cycle with all outputs at defaults.
- Transitions:
  - Fetch→Decode.
  - Decode→ by opcode:
    - MemAdr: op=0000011 or 0100011
    - ExecuteR: op=0110011
    - ExecuteI: op=0010011
    - BEQ: op=1100011
    - JAL: op=1101111
    - Fetch, with Illegal=1: any other opcode
  - MemAdr→MemRead if op[5]=0, else MemWrite.
  - MemRead→MemWB.
  - ExecuteR, ExecuteI, JAL→ALUWB.
  - MemWB, MemWrite, ALUWB, BEQ→Fetch.
- Defaults (any signal not listed for a state): all enables 0, selects 00, ALUOp=00.
- Per-state outputs:
  - Fetch: IRWrite=1, PCUpdate=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - Decode: ALUSrcA=01, ALUSrcB=01 (branch/jump target precomputed into ALUOut).
  - MemAdr: ALUSrcA=10, ALUSrcB=01.
  - MemRead: AdrSrc=1, ResultSrc=00.
  - MemWB: ResultSrc=01, RegWrite=1.
  - MemWrite: AdrSrc=1, MemWrite=1.
  - ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])). funct3=000 is beq; funct3=001 is bne.
- ImmSrc is combinational from op in every state:
  - lw/I-ALU → 00
  - sw → 01
  - branch → 10
  - jal → 11
  - otherwise → 00
- ALU decoder feed: ALUOp from the state, funct3 direct, and a gated funct7b5:
  - gated funct7b5 = funct7b5 & (op[5] | funct3==101)
  - This keeps addi with a negative immediate from becoming sub while still allowing srai.
- InstrDone=1 in MemWB, MemWrite, ALUWB and BEQ.

## Timing
- Next state registers on the rising edge. All outputs are decoded from the current state plus op/funct/Zero, with no added register stage.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - beq/bne 3
  - jal 4 (Fetch, Decode, JAL, ALUWB)
  - illegal opcode 2
- Reset:
  - While reset=1: State=Fetch, and PCWrite, IRWrite, RegWrite, MemWrite, InstrDone, Illegal are forced to 0. Selects show Fetch values.
  - The first edge with reset=0 executes Fetch.
  - Reset asserted in any state returns to Fetch on that edge. No partial write may occur in the reset cycle.
- op/funct3/funct7b5 must be stable from Decode until the instruction's last state; IR updates only in Fetch.
- Zero is sampled combinationally in BEQ only.

## Test plan
- Reset then lw (op=0000011): State sequence 0,1,2,3,4,0. Required values:
  - IRWrite=1 and PCWrite=1 only in Fetch
  - AdrSrc=1 in MemRead
  - RegWrite=1 and ResultSrc=01 in MemWB
  - InstrDone pulses once
- sw (op=0100011): sequence 0,1,2,5,0. Required values:
  - MemWrite=1 only in state 5
  - ImmSrc=01
  - RegWrite never asserted
- R-type sub (funct3=000, funct7b5=1): ALUControl=0001 in ExecuteR. addi (op=0010011, funct3=000, funct7b5=1): ALUControl=0000. srai (funct3=101, funct7b5=1): ALUControl=1001.
- beq with Zero=1 → PCWrite=1 in BEQ; Zero=0 → PCWrite=0. bne (funct3=001) with Zero=0 → PCWrite=1. All branches complete in 3 cycles with ALUControl=0001 in BEQ.
- jal: sequence 0,1,9,7,0. Required values:
  - PCWrite=1 in JAL
  - ALUSrcA=01 and ALUSrcB=10 in JAL
  - RegWrite=1 in ALUWB
- Illegal op=1111111: Decode asserts Illegal for 1 cycle and returns to Fetch. Separately, reset asserted during MemWrite gives MemWrite=0 that cycle and State=0 next cycle.
